dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (256 x 32, synchronous write, combinational read) between two requesters: port C (core load/store unit) and port D (DMA/debug loader).
- Sits between the requesters and the data memory instance and drives its clk-domain we/a/wd inputs.
- Core has priority. A consecutive-grant counter stops the core from starving port D.
- Read data is registered, so each requester sees a fixed one-cycle read latency.

Parameters:
- ADDR_W, 8, word-address width of each requester port; zero-extended to 32 bits on mem_a.
- MAX_CONSEC, 4, maximum back-to-back core grants while port D is waiting (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- c_req  in  1  core access request; held until c_gnt
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core word address
- c_wdata  in  32  core write data
- c_gnt  out  1  core access performed this cycle
- c_rvalid  out  1  c_rdata valid (one cycle after a read grant)
- c_rdata  out  32  registered core read data
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: identical set for port D
- mem_we  out  1  to memory we
- mem_a  out  32  to memory a
- mem_wd  out  32  to memory wd
- mem_rd  in  32  from memory rd

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high. While rst=1, c_gnt=d_gnt=0 and mem_we=0 (combinationally forced). On the reset edge, c_rvalid=d_rvalid=0, c_rdata=d_rdata=0, cnt=0. mem_a and mem_wd show port C fields with we gated off.
- Arbitration is combinational within the cycle, and at most one grant is issued per cycle:
  - Only c_req: C wins.
  - Only d_req: D wins.
  - Both requesting: C wins if cnt < MAX_CONSEC, otherwise D wins.
  - Neither: no grant, mem_we=0, mem_a/mem_wd follow port C.
- Memory drive: mem_a = zero-extended winner addr; mem_wd = winner wdata; mem_we = winner we & gnt.
- A write grant commits on that clock edge.
- Starvation counter cnt (4 bits), updated on each edge:
  - C granted while d_req=1: cnt+1, saturating at MAX_CONSEC.
  - D granted, or d_req=0: cnt cleared to 0.
- Read response:
  - On a read grant to port X, X_rdata <= mem_rd and X_rvalid <= 1 for exactly the next cycle.
  - Write grants and idle cycles set X_rvalid <= 0.
  - X_rdata holds its value until the next read to X.
- Handshake: a requester must hold req and its fields stable until it sees gnt. Dropping req before gnt is legal, the request is simply lost, and no state changes.
- Back-to-back grants to the same port on consecutive cycles are allowed (throughput of 1 access per cycle).
- Read-after-write to the same address on the next cycle returns the new data.
- Reset asserted mid-stream: a pending rvalid is cleared and cnt is cleared. Any grant in the reset cycle is suppressed, so nothing is written.
- Address bits above ADDR_W are always 0. There is no range checking.

Test Plan:
- Reset: hold rst 2 cycles with c_req=d_req=1, c_we=1 -> c_gnt=d_gnt=0, mem_we=0; memory word unchanged; both rvalid=0, both rdata=0.
- Core write then read: C writes addr 0x10 data 0xDEADBEEF, then reads 0x10 next cycle -> c_gnt=1 both cycles; c_rvalid=1 with c_rdata=0xDEADBEEF one cycle after the read grant.
- Solo D: d_req read addr 0x05 (preloaded 0x12345678), c_req=0 -> d_gnt same cycle; d_rvalid/d_rdata=0x12345678 next cycle; cnt stays 0.
- Starvation guard (MAX_CONSEC=4): c_req and d_req held high continuously -> grant pattern C,C,C,C,D,C,C,C,C,D; cnt resets after each D grant.
- Contention with writes: C writes 0xAAAA0000 and D writes 0x0000BBBB to the same address 0x20, both requesting -> C wins first, D wins a later cycle; final read of 0x20 returns 0x0000BBBB.
- Reset mid-read: C read granted, rst asserted on the following edge -> c_rvalid=0 after that edge; cnt=0; no write occurs during the reset cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port priority arbiter in front of the single-port data memory
//
// Purpose: shares one 256x32 data memory (sync write, comb read) between the
// core port (C, priority) and the DMA/debug loader port (D). A saturating
// consecutive-grant counter keeps the core from starving port D. Read data is
// registered, so each port sees a fixed one-cycle read latency.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata core request fields (held until c_gnt)
//   c_gnt                     core access performed this cycle
//   c_rvalid/c_rdata          registered core read response
//   d_*                       identical set for port D
//   mem_we/mem_a/mem_wd       drive to the memory instance
//   mem_rd                    combinational read data from the memory
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

  logic [3:0] cnt;
  logic       c_win;
  logic       d_win;

  // The core loses a contended cycle only once it has used up its run of
  // back-to-back grants while D was waiting.
  always_comb begin
    c_win = c_req & (~d_req | (cnt < MAX_C));
    d_win = d_req & ~c_win;
  end

  // Grants are suppressed during reset so nothing reaches the memory.
  assign c_gnt = c_win & ~rst;
  assign d_gnt = d_win & ~rst;

  // Mux defaults to port C whenever D is not actually granted.
  always_comb begin
    mem_a  = 32'(c_addr);
    mem_wd = c_wdata;
    mem_we = c_gnt & c_we;
    if (d_gnt) begin
      mem_a  = 32'(d_addr);
      mem_wd = d_wdata;
      mem_we = d_we;
    end
  end

  // Starvation counter: counts core grants taken while D is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (c_gnt && d_req) begin
      if (cnt < MAX_C) begin
        cnt <= cnt + 4'd1;
      end
    end else begin
      cnt <= 4'd0;
    end
  end

  // Read responses: rdata holds until the next read to the same port.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      c_rdata  <= 32'd0;
      d_rvalid <= 1'b0;
      d_rdata  <= 32'd0;
    end else begin
      c_rvalid <= c_gnt & ~c_we;
      d_rvalid <= d_gnt & ~d_we;
      if (c_gnt && !c_we) begin
        c_rdata <= mem_rd;
      end
      if (d_gnt && !d_we) begin
        d_rdata <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven directed bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [7:0]  c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [256];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .MAX_CONSEC(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:0]] <= mem_wd;
  end
  assign mem_rd = mem[mem_a[7:0]];

  typedef struct {
    logic        rst;
    logic        c_req, c_we;
    logic [7:0]  c_addr;
    logic [31:0] c_wdata;
    logic        d_req, d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        e_cg, e_dg, e_we;
    logic [31:0] e_a, e_wd;
    logic        e_cv;
    logic [31:0] e_cd;
    logic        e_dv;
    logic [31:0] e_dd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
    input logic dr, input logic dw, input logic [7:0] da, input logic [31:0] dd,
    input logic ecg, input logic edg, input logic ewe, input logic [31:0] ea, input logic [31:0] ewd,
    input logic ecv, input logic [31:0] ecd, input logic edv, input logic [31:0] edd);
    vec_t v;
    v.rst = r; v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
    v.e_cg = ecg; v.e_dg = edg; v.e_we = ewe; v.e_a = ea; v.e_wd = ewd;
    v.e_cv = ecv; v.e_cd = ecd; v.e_dv = edv; v.e_dd = edd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst;
    c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    #1;
    vectors++;
    chk("c_gnt",  idx, 32'(c_gnt),  32'(v.e_cg));
    chk("d_gnt",  idx, 32'(d_gnt),  32'(v.e_dg));
    chk("mem_we", idx, 32'(mem_we), 32'(v.e_we));
    chk("mem_a",  idx, mem_a,       v.e_a);
    chk("mem_wd", idx, mem_wd,      v.e_wd);
    @(posedge clk);
    #1;
    chk("c_rvalid", idx, 32'(c_rvalid), 32'(v.e_cv));
    chk("c_rdata",  idx, c_rdata,       v.e_cd);
    chk("d_rvalid", idx, 32'(d_rvalid), 32'(v.e_dv));
    chk("d_rdata",  idx, d_rdata,       v.e_dd);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] PL = 32'h12345678;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    mem[5] <= PL;
    rst = 1'b1; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

    // reset held two cycles with both ports trying to write
    tbl.push_back(mk(1, 1,1,8'h10,32'h11111111, 1,1,8'h10,32'h22222222, 0,0,0,32'h10,32'h11111111, 0,0, 0,0));
    tbl.push_back(mk(1, 1,1,8'h10,32'h11111111, 1,1,8'h10,32'h22222222, 0,0,0,32'h10,32'h11111111, 0,0, 0,0));
    // core write then read-after-write
    tbl.push_back(mk(0, 1,1,8'h10,DB, 0,0,8'h00,0, 1,0,1,32'h10,DB, 0,0, 0,0));
    tbl.push_back(mk(0, 1,0,8'h10,0,  0,0,8'h00,0, 1,0,0,32'h10,0,  1,DB, 0,0));
    tbl.push_back(mk(0, 0,0,8'h00,0,  0,0,8'h00,0, 0,0,0,32'h00,0,  0,DB, 0,0));
    // solo D read of preloaded word
    tbl.push_back(mk(0, 0,0,8'h33,0,  1,0,8'h05,0, 0,1,0,32'h05,0,  0,DB, 1,PL));
    tbl.push_back(mk(0, 0,0,8'h00,0,  0,0,8'h00,0, 0,0,0,32'h00,0,  0,DB, 0,PL));
    // both reading continuously: C,C,C,C,D repeated
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4)
        tbl.push_back(mk(0, 1,0,8'h10,0, 1,0,8'h05,0, 0,1,0,32'h05,0, 0,DB, 1,PL));
      else
        tbl.push_back(mk(0, 1,0,8'h10,0, 1,0,8'h05,0, 1,0,0,32'h10,0, 1,DB, 0,PL));
    end
    // contended writes to 0x20: C first, then D, then read back
    tbl.push_back(mk(0, 1,1,8'h20,32'hAAAA0000, 1,1,8'h20,32'h0000BBBB, 1,0,1,32'h20,32'hAAAA0000, 0,DB, 0,PL));
    tbl.push_back(mk(0, 0,0,8'h00,0,            1,1,8'h20,32'h0000BBBB, 0,1,1,32'h20,32'h0000BBBB, 0,DB, 0,PL));
    tbl.push_back(mk(0, 1,0,8'h20,0,            0,0,8'h00,0,            1,0,0,32'h20,0, 1,32'h0000BBBB, 0,PL));
    tbl.push_back(mk(0, 0,0,8'h00,0,            0,0,8'h00,0,            0,0,0,32'h00,0, 0,32'h0000BBBB, 0,PL));
    // C read granted while D waits, then reset with both writing
    tbl.push_back(mk(0, 1,0,8'h05,0,            1,1,8'h30,32'hCAFEF00D, 1,0,0,32'h05,0, 1,PL, 0,PL));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
      if (i == 1) begin
        vectors++;
        chk("mem10_after_reset", i, mem[8'h10], 32'd0);
      end
      if (i == 5) begin
        vectors++;
        chk("cnt_after_solo_d", i, 32'(dut.cnt), 32'd0);
      end
      if (i == tbl.size() - 1) begin
        vectors++;
        chk("cnt_before_reset", i, 32'(dut.cnt), 32'd1);
      end
    end

    // reset mid-stream: pending rvalid dropped, cnt cleared, nothing written
    apply(mk(1, 1,1,8'h30,32'h55555555, 1,1,8'h30,32'h66666666, 0,0,0,32'h30,32'h55555555, 0,0, 0,0), 100);
    vectors++;
    chk("cnt_after_reset", 100, 32'(dut.cnt), 32'd0);
    vectors++;
    chk("mem30_after_reset", 100, mem[8'h30], 32'd0);
    vectors++;
    chk("mem20_final", 100, mem[8'h20], 32'h0000BBBB);

    // request dropped before grant leaves no trace
    apply(mk(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,32'h00,0, 0,0, 0,0), 101);
    vectors++;
    chk("cnt_idle", 101, 32'(dut.cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
